// File: rtl/adder_pkg.sv
// rtl/adder_pkg.sv - shared state encoding and sizing helpers for serial_chunk_adder
package adder_pkg;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  function automatic int nchunk(input int width, input int chunk);
    return width / chunk;
  endfunction

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int v = n - 1; v > 0; v = v >> 1) r++;
    return r;
  endfunction

endpackage

// File: rtl/chunk_cla.sv
// rtl/chunk_cla.sv - combinational CHUNK-bit carry-lookahead slice
module chunk_cla #(
  parameter int CHUNK = 4
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             ci,
  output logic [CHUNK-1:0] s,
  output logic             co,
  output logic             p,
  output logic             c_msb
);

  logic [CHUNK-1:0] gen;
  logic [CHUNK-1:0] prop;
  logic [CHUNK:0]   carry;

  // Each carry is the flattened lookahead sum of generate terms plus the propagated carry-in
  always_comb begin
    logic c_acc;
    logic p_acc;
    gen      = a & b;
    prop     = a ^ b;
    carry    = '0;
    carry[0] = ci;
    for (int i = 0; i < CHUNK; i++) begin
      c_acc = gen[i];
      p_acc = prop[i];
      for (int j = i - 1; j >= 0; j--) begin
        c_acc = c_acc | (p_acc & gen[j]);
        p_acc = p_acc & prop[j];
      end
      carry[i+1] = c_acc | (p_acc & ci);
    end
    s     = prop ^ carry[CHUNK-1:0];
    co    = carry[CHUNK];
    p     = &prop;
    c_msb = carry[CHUNK-1];
  end

endmodule

// File: rtl/serial_chunk_adder.sv
// rtl/serial_chunk_adder.sv - multi-cycle chunked adder with valid/ready handshakes; optional subtract under ADD_SUB_EN
module serial_chunk_adder
  import adder_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
`ifdef ADD_SUB_EN
  input  logic             Sub,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] S,
  output logic             Cout,
  output logic             P,
  output logic             V
);

  localparam int NCH = nchunk(WIDTH, CHUNK);
  localparam int KW  = (NCH > 1) ? clog2(NCH) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(NCH - 1);

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, s_q, s_d;
  logic [KW-1:0]    k_q, k_d;
  logic             carry_q, carry_d, cout_q, cout_d, p_q, p_d, v_q, v_d;

  logic [WIDTH-1:0] b_eff;
  logic             cin_eff;
  logic [CHUNK-1:0] cla_s;
  logic             cla_co, cla_p, cla_c_msb;

  // Operand conditioning: subtract is A + ~B + 1, carry-in ignored
  always_comb begin
`ifdef ADD_SUB_EN
    b_eff   = Sub ? ~B : B;
    cin_eff = Sub ? 1'b1 : Cin;
`else
    b_eff   = B;
    cin_eff = Cin;
`endif
  end

  // Operands are shifted down so the active chunk always sits in the low bits
  chunk_cla #(.CHUNK(CHUNK)) u_cla (
    .a     (a_q[CHUNK-1:0]),
    .b     (b_q[CHUNK-1:0]),
    .ci    (carry_q),
    .s     (cla_s),
    .co    (cla_co),
    .p     (cla_p),
    .c_msb (cla_c_msb)
  );

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state: capture, run NCH chunks, hold result until consumed
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid) state_d = RUN;
      RUN:     if (k_q == K_LAST) state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Handshake outputs decoded from state
  always_comb begin
    in_ready  = (state_q == IDLE);
    out_valid = (state_q == DONE);
  end

  // Datapath next values: capture in IDLE, one chunk per RUN cycle, hold otherwise
  always_comb begin
    a_d     = a_q;
    b_d     = b_q;
    s_d     = s_q;
    k_d     = k_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    p_d     = p_q;
    v_d     = v_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = A;
          b_d     = b_eff;
          carry_d = cin_eff;
          s_d     = '0;
          k_d     = '0;
          cout_d  = 1'b0;
          p_d     = 1'b1;
          v_d     = 1'b0;
        end
      end
      RUN: begin
        a_d                   = a_q >> CHUNK;
        b_d                   = b_q >> CHUNK;
        s_d[k_q*CHUNK+:CHUNK] = cla_s;
        carry_d               = cla_co;
        p_d                   = p_q & cla_p;
        k_d                   = k_q + 1'b1;
        if (k_q == K_LAST) begin
          k_d    = '0;
          cout_d = cla_co;
          v_d    = cla_c_msb ^ cla_co;
        end
      end
      default: ;
    endcase
  end

  // Datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q     <= '0;
      b_q     <= '0;
      s_q     <= '0;
      k_q     <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      p_q     <= 1'b0;
      v_q     <= 1'b0;
    end else begin
      a_q     <= a_d;
      b_q     <= b_d;
      s_q     <= s_d;
      k_q     <= k_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      p_q     <= p_d;
      v_q     <= v_d;
    end
  end

  assign S    = s_q;
  assign Cout = cout_q;
  assign P    = p_q;
  assign V    = v_q;

endmodule

// File: tb/tb_serial_chunk_adder.sv
// tb/tb_serial_chunk_adder.sv - self-checking bench for serial_chunk_adder (8/2 and 8/8 builds)
module tb_serial_chunk_adder;

  localparam int W = 8;
  localparam int C = 2;
  localparam int N = W / C;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0, out_ready = 1'b0, Cin = 1'b0, Sub = 1'b0;
  logic [W-1:0] A = '0, B = '0;
  logic         in_ready, out_valid, Cout, P, V;
  logic [W-1:0] S;

  logic         in_valid_f = 1'b0, out_ready_f = 1'b0, Cin_f = 1'b0, Sub_f = 1'b0;
  logic [W-1:0] A_f = '0, B_f = '0;
  logic         in_ready_f, out_valid_f, Cout_f, P_f, V_f;
  logic [W-1:0] S_f;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  serial_chunk_adder #(.WIDTH(W), .CHUNK(C)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .A(A), .B(B), .Cin(Cin),
`ifdef ADD_SUB_EN
    .Sub(Sub),
`endif
    .out_valid(out_valid), .out_ready(out_ready),
    .S(S), .Cout(Cout), .P(P), .V(V)
  );

  serial_chunk_adder #(.WIDTH(W), .CHUNK(W)) dut_f (
    .clk(clk), .rst(rst), .in_valid(in_valid_f), .in_ready(in_ready_f),
    .A(A_f), .B(B_f), .Cin(Cin_f),
`ifdef ADD_SUB_EN
    .Sub(Sub_f),
`endif
    .out_valid(out_valid_f), .out_ready(out_ready_f),
    .S(S_f), .Cout(Cout_f), .P(P_f), .V(V_f)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: {v,p,cout,s} from plain integer arithmetic on the effective operands
  function automatic logic [W+2:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                         input logic cin, input logic sub);
    logic [W-1:0] be;
    logic         ce;
    logic [W:0]   sum;
    logic         ov;
    be  = sub ? ~b : b;
    ce  = sub ? 1'b1 : cin;
    sum = {1'b0, a} + {1'b0, be} + {{W{1'b0}}, ce};
    ov  = (a[W-1] == be[W-1]) && (sum[W-1] != a[W-1]);
    return {ov, &(a ^ be), sum};
  endfunction

  // One full transaction on the 8/2 instance; sampled on negedges
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                        input logic sub, input int hold);
    logic [W+2:0] e;
    int lat;
    int waited;
    e = model(a, b, cin, sub);
    waited = 0;
    while (!in_ready && waited < 10) begin @(negedge clk); waited++; end
    check("in_ready_before_capture", in_ready, 1'b1);
    A = a; B = b; Cin = cin; Sub = sub; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    check("in_ready_in_run", in_ready, 1'b0);
    lat = 0;
    while (!out_valid && lat < 50) begin @(negedge clk); lat++; end
    check("latency", lat, N);
    check("S", S, e[W-1:0]);
    check("Cout", Cout, e[W]);
    check("P", P, e[W+1]);
    check("V", V, e[W+2]);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check("hold_out_valid", out_valid, 1'b1);
      check("hold_S", S, e[W-1:0]);
      check("hold_in_ready", in_ready, 1'b0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("after_accept_out_valid", out_valid, 1'b0);
    check("after_accept_in_ready", in_ready, 1'b1);
    check("after_accept_S_held", S, e[W-1:0]);
  endtask

  initial begin
    logic [W+2:0] e;
    logic         rs;

    // Reset state
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_in_ready", in_ready, 1'b1);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_S", S, 8'h00);
    check("rst_Cout", Cout, 1'b0);
    check("rst_P", P, 1'b0);
    check("rst_V", V, 1'b0);

    // Directed cases
    run_op(8'hFF, 8'h01, 1'b0, 1'b0, 0);
    run_op(8'h0F, 8'hF0, 1'b1, 1'b0, 0);
    run_op(8'h7F, 8'h01, 1'b0, 1'b0, 5);

    // Reset two cycles into RUN aborts the operation
    A = 8'h55; B = 8'h66; Cin = 1'b1; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b1;
    #1;
    check("abort_in_ready", in_ready, 1'b1);
    check("abort_out_valid", out_valid, 1'b0);
    check("abort_S", S, 8'h00);
    check("abort_Cout", {Cout, P, V}, 3'b000);
    @(negedge clk);
    rst = 1'b0;
    repeat (N + 1) @(negedge clk);
    check("abort_no_result", out_valid, 1'b0);
    run_op(8'h03, 8'h04, 1'b0, 1'b0, 0);

`ifdef ADD_SUB_EN
    run_op(8'h05, 8'h07, 1'b0, 1'b1, 0);
    run_op(8'h07, 8'h05, 1'b1, 1'b1, 0);
`endif

    // Randomized operands against the model
    for (int i = 0; i < 24; i++) begin
`ifdef ADD_SUB_EN
      rs = 1'($urandom_range(0, 1));
`else
      rs = 1'b0;
`endif
      run_op(W'($urandom), W'($urandom), 1'($urandom_range(0, 1)), rs, int'($urandom_range(0, 2)));
    end

    // Single-chunk instance: result one cycle after capture
    for (int i = 0; i < 6; i++) begin
      A_f = W'($urandom); B_f = W'($urandom); Cin_f = 1'($urandom_range(0, 1));
`ifdef ADD_SUB_EN
      Sub_f = 1'($urandom_range(0, 1));
`else
      Sub_f = 1'b0;
`endif
      e = model(A_f, B_f, Cin_f, Sub_f);
      check("full_in_ready", in_ready_f, 1'b1);
      in_valid_f = 1'b1;
      @(posedge clk);
      @(negedge clk);
      in_valid_f = 1'b0;
      check("full_not_yet_valid", out_valid_f, 1'b0);
      @(negedge clk);
      check("full_out_valid", out_valid_f, 1'b1);
      check("full_S", S_f, e[W-1:0]);
      check("full_flags", {V_f, P_f, Cout_f}, e[W+2:W]);
      out_ready_f = 1'b1;
      @(negedge clk);
      out_ready_f = 1'b0;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
